adder_stream_ctrl: RTL and testbench

- Stream front-end for the registered 4-bit adder stage. Accepts operand pairs over a valid/ready handshake and buffers them in an operand FIFO.
- Issues at most one pair per cycle to the adder and tracks in-flight operations against the adder's fixed latency.
- Captures {carry, sum} into a result FIFO and presents results downstream over valid/ready.
- Issue is credit-gated, so a result is never dropped.

---
 rtl/adder_stream_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_adder_stream_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_stream_ctrl.sv
// Valid/ready stream front-end for a registered 4-bit adder, with operand and result FIFOs and credit-gated issue.
// Optional carry-pop counter enabled by defining ADDER_STREAM_CTRL_CARRY_CNT_EN.
module adder_stream_ctrl #(
    parameter int OP_DEPTH    = 4,
    parameter int RES_DEPTH   = 4,
    parameter int ADD_LATENCY = 1
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iREQ_VALID,
    output logic        oREQ_READY,
    input  logic [3:0]  iREQ_A,
    input  logic [3:0]  iREQ_B,
    output logic [3:0]  oADD_A,
    output logic [3:0]  oADD_B,
    input  logic [3:0]  iADD_DATA,
    input  logic        iADD_C,
    output logic        oRESULT_VALID,
    input  logic        iRESULT_READY,
    output logic [3:0]  oRESULT_DATA,
    output logic        oRESULT_C,
    output logic        oBUSY
`ifdef ADDER_STREAM_CTRL_CARRY_CNT_EN
    ,
    input  logic        iCARRY_CNT_CLR,
    output logic [15:0] oCARRY_CNT
`endif
);

    localparam int OAW = $clog2(OP_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int OCW = OAW + 1;
    localparam int RCW = RAW + 1;
    localparam int ICW = $clog2(ADD_LATENCY + 2);
    localparam logic [OCW-1:0] OP_FULL = OCW'(OP_DEPTH);

    function automatic logic [ICW-1:0] popcount(input logic [ADD_LATENCY:0] v);
        logic [ICW-1:0] n;
        n = {ICW{1'b0}};
        for (int i = 0; i <= ADD_LATENCY; i++) begin
            n = n + {{(ICW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [3:0]       op_a_q [OP_DEPTH];
    logic [3:0]       op_a_d [OP_DEPTH];
    logic [3:0]       op_b_q [OP_DEPTH];
    logic [3:0]       op_b_d [OP_DEPTH];
    logic [OAW-1:0]   op_wr_q, op_wr_d, op_rd_q, op_rd_d;
    logic [OCW-1:0]   op_cnt_q, op_cnt_d;
    logic [4:0]       res_mem_q [RES_DEPTH];
    logic [4:0]       res_mem_d [RES_DEPTH];
    logic [RAW-1:0]   res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [RCW-1:0]   res_cnt_q, res_cnt_d;
    logic [ADD_LATENCY:0] issue_v_q, issue_v_d;
    logic [3:0]       add_a_q, add_a_d, add_b_q, add_b_d;
    logic             ready_q, ready_d;

    logic             op_empty_s, res_empty_s, push_s, issue_s, capture_s, pop_s;
    logic [ICW-1:0]   inflight_s;
    logic [31:0]      credit_used_s;
    logic [4:0]       res_head_s;

    assign op_empty_s    = (op_cnt_q == {OCW{1'b0}});
    assign res_empty_s   = (res_cnt_q == {RCW{1'b0}});
    assign inflight_s    = popcount(issue_v_q);
    // Credits count everything that will land in the result FIFO, so capture can never overflow it.
    assign credit_used_s = 32'(res_cnt_q) + 32'(inflight_s);
    assign push_s        = iREQ_VALID && ready_q;
    assign issue_s       = !op_empty_s && (credit_used_s < 32'(RES_DEPTH));
    assign capture_s     = issue_v_q[ADD_LATENCY];
    assign res_head_s    = res_empty_s ? 5'd0 : res_mem_q[res_rd_q];
    assign pop_s         = !res_empty_s && iRESULT_READY;

    assign oREQ_READY    = ready_q;
    assign oADD_A        = add_a_q;
    assign oADD_B        = add_b_q;
    assign oRESULT_VALID = !res_empty_s;
    assign oRESULT_DATA  = res_head_s[3:0];
    assign oRESULT_C     = res_head_s[4];
    assign oBUSY         = !op_empty_s || (inflight_s != {ICW{1'b0}}) || !res_empty_s;

    // Operand FIFO, issue register and in-flight tracking.
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_wr_d  = op_wr_q;
        op_rd_d  = op_rd_q;
        op_cnt_d = op_cnt_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        if (push_s) begin
            op_a_d[op_wr_q] = iREQ_A;
            op_b_d[op_wr_q] = iREQ_B;
            op_wr_d         = op_wr_q + OAW'(1);
        end else begin
            op_wr_d = op_wr_q;
        end
        if (issue_s) begin
            add_a_d = op_a_q[op_rd_q];
            add_b_d = op_b_q[op_rd_q];
            op_rd_d = op_rd_q + OAW'(1);
        end else begin
            op_rd_d = op_rd_q;
        end
        case ({push_s, issue_s})
            2'b10:   op_cnt_d = op_cnt_q + OCW'(1);
            2'b01:   op_cnt_d = op_cnt_q - OCW'(1);
            default: op_cnt_d = op_cnt_q;
        endcase
        // Ready follows the next registered count, so a pop while full opens a slot only a cycle later.
        ready_d   = (op_cnt_d != OP_FULL);
        issue_v_d = {issue_v_q[ADD_LATENCY-1:0], issue_s};
    end

    // Result FIFO: unconditional capture from the adder, pop on downstream handshake.
    always_comb begin
        res_mem_d = res_mem_q;
        res_wr_d  = res_wr_q;
        res_rd_d  = res_rd_q;
        res_cnt_d = res_cnt_q;
        if (capture_s) begin
            res_mem_d[res_wr_q] = {iADD_C, iADD_DATA};
            res_wr_d            = res_wr_q + RAW'(1);
        end else begin
            res_wr_d = res_wr_q;
        end
        if (pop_s) begin
            res_rd_d = res_rd_q + RAW'(1);
        end else begin
            res_rd_d = res_rd_q;
        end
        case ({capture_s, pop_s})
            2'b10:   res_cnt_d = res_cnt_q + RCW'(1);
            2'b01:   res_cnt_d = res_cnt_q - RCW'(1);
            default: res_cnt_d = res_cnt_q;
        endcase
    end

    // State registers.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            op_a_q    <= '{default: 4'd0};
            op_b_q    <= '{default: 4'd0};
            op_wr_q   <= {OAW{1'b0}};
            op_rd_q   <= {OAW{1'b0}};
            op_cnt_q  <= {OCW{1'b0}};
            res_mem_q <= '{default: 5'd0};
            res_wr_q  <= {RAW{1'b0}};
            res_rd_q  <= {RAW{1'b0}};
            res_cnt_q <= {RCW{1'b0}};
            issue_v_q <= {(ADD_LATENCY+1){1'b0}};
            add_a_q   <= 4'd0;
            add_b_q   <= 4'd0;
            ready_q   <= 1'b0;
        end else begin
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_wr_q   <= op_wr_d;
            op_rd_q   <= op_rd_d;
            op_cnt_q  <= op_cnt_d;
            res_mem_q <= res_mem_d;
            res_wr_q  <= res_wr_d;
            res_rd_q  <= res_rd_d;
            res_cnt_q <= res_cnt_d;
            issue_v_q <= issue_v_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            ready_q   <= ready_d;
        end
    end

`ifdef ADDER_STREAM_CTRL_CARRY_CNT_EN
    logic [15:0] carry_cnt_q, carry_cnt_d;

    // Saturating count of popped results with carry set; clear wins.
    always_comb begin
        carry_cnt_d = carry_cnt_q;
        if (iCARRY_CNT_CLR) begin
            carry_cnt_d = 16'd0;
        end else if (pop_s && res_head_s[4] && (carry_cnt_q != 16'hFFFF)) begin
            carry_cnt_d = carry_cnt_q + 16'd1;
        end else begin
            carry_cnt_d = carry_cnt_q;
        end
    end

    // Carry counter register.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            carry_cnt_q <= 16'd0;
        end else begin
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign oCARRY_CNT = carry_cnt_q;
`endif

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// Directed, table-driven bench for adder_stream_ctrl with a behavioural 1-cycle registered adder.
module tb_adder_stream_ctrl;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       c;
    } vec_t;

    logic       iCLOCK = 1'b0;
    logic       inRESET = 1'b1;
    logic       iREQ_VALID, iRESULT_READY;
    logic [3:0] iREQ_A, iREQ_B;
    logic       oREQ_READY, oRESULT_VALID, oRESULT_C, oBUSY, iADD_C;
    logic [3:0] oADD_A, oADD_B, iADD_DATA, oRESULT_DATA;
    logic [4:0] add_q = 5'd0;
`ifdef ADDER_STREAM_CTRL_CARRY_CNT_EN
    logic        iCARRY_CNT_CLR;
    logic [15:0] oCARRY_CNT;
`endif

    vec_t vt [40];
    int   total = 0;
    int   bad = 0;
    int   stalls;
    int   acc;
    logic acc_now;

    always #5 iCLOCK = ~iCLOCK;

    always @(posedge iCLOCK) add_q <= {1'b0, oADD_A} + {1'b0, oADD_B};
    assign iADD_DATA = add_q[3:0];
    assign iADD_C    = add_q[4];

    adder_stream_ctrl dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET),
        .iREQ_VALID(iREQ_VALID), .oREQ_READY(oREQ_READY),
        .iREQ_A(iREQ_A), .iREQ_B(iREQ_B),
        .oADD_A(oADD_A), .oADD_B(oADD_B),
        .iADD_DATA(iADD_DATA), .iADD_C(iADD_C),
        .oRESULT_VALID(oRESULT_VALID), .iRESULT_READY(iRESULT_READY),
        .oRESULT_DATA(oRESULT_DATA), .oRESULT_C(oRESULT_C),
        .oBUSY(oBUSY)
`ifdef ADDER_STREAM_CTRL_CARRY_CNT_EN
        , .iCARRY_CNT_CLR(iCARRY_CNT_CLR), .oCARRY_CNT(oCARRY_CNT)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic push(input int first, input int n, output int st);
        st = 0;
        for (int k = 0; k < n; k++) begin
            iREQ_A = vt[first+k].a;
            iREQ_B = vt[first+k].b;
            iREQ_VALID = 1'b1;
            for (int w = 0; w < 100 && !oREQ_READY; w++) begin
                tick();
                st++;
            end
            tick();
        end
        iREQ_VALID = 1'b0;
    endtask

    task automatic collect(input int first, input int n, input bit rate);
        int got = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
            if (oRESULT_VALID && iRESULT_READY) begin
                check("res_data", oRESULT_DATA, vt[first+got].d);
                check("res_carry", oRESULT_C, vt[first+got].c);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            tick();
        end
        check("res_count", got, n);
        if (rate) check("one_per_cycle", last_cyc - first_cyc, n - 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4'h9, 4'h8, 4'h1, 1'b1};
        vt[1] = '{4'h0, 4'h0, 4'h0, 1'b0};
        vt[2] = '{4'hF, 4'hF, 4'hE, 1'b1};
        vt[3] = '{4'h7, 4'h8, 4'hF, 1'b0};
        vt[4] = '{4'h8, 4'h8, 4'h0, 1'b1};
        vt[5] = '{4'h3, 4'h4, 4'h7, 1'b0};
        vt[6] = '{4'hF, 4'h1, 4'h0, 1'b1};
        vt[7] = '{4'hA, 4'h5, 4'hF, 1'b0};
        for (int i = 0; i < 16; i++) vt[8+i] = '{4'(i), 4'(15-i), 4'hF, 1'b0};
        vt[24] = '{4'h1, 4'h2, 4'h3, 1'b0};
        vt[25] = '{4'h2, 4'h3, 4'h5, 1'b0};
        vt[26] = '{4'h3, 4'h4, 4'h7, 1'b0};
        vt[27] = '{4'h4, 4'h5, 4'h9, 1'b0};
        vt[28] = '{4'h5, 4'h6, 4'hB, 1'b0};
        vt[29] = '{4'h6, 4'h7, 4'hD, 1'b0};
        vt[30] = '{4'h7, 4'h8, 4'hF, 1'b0};
        vt[31] = '{4'h8, 4'h9, 4'h1, 1'b1};
        vt[32] = '{4'h9, 4'hA, 4'h3, 1'b1};
        vt[33] = '{4'hA, 4'hB, 4'h5, 1'b1};
        vt[34] = '{4'hF, 4'hF, 4'hE, 1'b1};
        vt[35] = '{4'h8, 4'h8, 4'h0, 1'b1};
        vt[36] = '{4'h9, 4'h8, 4'h1, 1'b1};
        vt[37] = '{4'hF, 4'h1, 4'h0, 1'b1};
        vt[38] = '{4'hC, 4'h4, 4'h0, 1'b1};

        iREQ_VALID = 1'b0; iREQ_A = 4'd0; iREQ_B = 4'd0; iRESULT_READY = 1'b0;
`ifdef ADDER_STREAM_CTRL_CARRY_CNT_EN
        iCARRY_CNT_CLR = 1'b0;
`endif
        #1 inRESET = 1'b0;
        #2;
        check("rst_ready", oREQ_READY, 0);
        check("rst_valid", oRESULT_VALID, 0);
        check("rst_data", oRESULT_DATA, 0);
        check("rst_carry", oRESULT_C, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_add_a", {oADD_A, oADD_B}, 0);
        tick();
        check("rst_ready_held", oREQ_READY, 0);
        #3 inRESET = 1'b1;
        tick();
        check("ready_after_rst", oREQ_READY, 1);

        // Single op: result visible exactly 3 edges after the accepting edge.
        iRESULT_READY = 1'b1;
        iREQ_A = vt[0].a; iREQ_B = vt[0].b; iREQ_VALID = 1'b1;
        tick();
        iREQ_VALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("single_early_valid", oRESULT_VALID, 0);
            tick();
        end
        check("single_early_valid", oRESULT_VALID, 0);
        tick();
        check("single_valid", oRESULT_VALID, 1);
        check("single_data", oRESULT_DATA, 4'h1);
        check("single_carry", oRESULT_C, 1);
        tick();
        check("single_idle_busy", oBUSY, 0);
        check("single_idle_valid", oRESULT_VALID, 0);

        // Table of assorted operand pairs.
        fork
            push(0, 8, stalls);
            collect(0, 8, 1'b0);
        join

        // 16-pair stream at full rate.
        fork
            push(8, 16, stalls);
            collect(8, 16, 1'b1);
        join
        check("stream_no_stall", stalls, 0);
        tick();
        check("stream_idle_busy", oBUSY, 0);

        // Downstream stall: 8 accepted, 4 issued.
        iRESULT_READY = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (acc < 10) begin
                iREQ_A = vt[24+acc].a; iREQ_B = vt[24+acc].b; iREQ_VALID = 1'b1;
            end else begin
                iREQ_VALID = 1'b0;
            end
            acc_now = oREQ_READY && iREQ_VALID;
            tick();
            if (acc_now) acc++;
        end
        iREQ_VALID = 1'b0;
        check("stall_accepted", acc, 8);
        check("stall_ready", oREQ_READY, 0);
        check("stall_last_issue", oADD_A, 4'h4);
        check("stall_head", oRESULT_DATA, 4'h3);
        check("stall_busy", oBUSY, 1);

        // One result pop while op FIFO is full.
        iRESULT_READY = 1'b1;
        tick();
        iRESULT_READY = 1'b0;
        check("fullpop_ready_same", oREQ_READY, 0);
        check("fullpop_no_issue_yet", oADD_A, 4'h4);
        tick();
        check("fullpop_ready_next", oREQ_READY, 1);
        check("fullpop_issued", oADD_A, 4'h5);
        iRESULT_READY = 1'b1;
        collect(25, 7, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        check("drain_valid", oRESULT_VALID, 0);
        check("drain_busy", oBUSY, 0);

        // Reset with ops queued, in flight and buffered.
        iRESULT_READY = 1'b0;
        push(8, 6, stalls);
        check("pre_rst_busy", oBUSY, 1);
        check("pre_rst_valid", oRESULT_VALID, 1);
        #2 inRESET = 1'b0;
        #1;
        check("mid_rst_valid", oRESULT_VALID, 0);
        check("mid_rst_data", {oRESULT_C, oRESULT_DATA}, 0);
        check("mid_rst_busy", oBUSY, 0);
        check("mid_rst_ready", oREQ_READY, 0);
        check("mid_rst_add", {oADD_A, oADD_B}, 0);
        tick();
        #3 inRESET = 1'b1;
        tick();
        check("post_rst_ready", oREQ_READY, 1);
        for (int k = 0; k < 5; k++) begin
            check("no_stale_result", oRESULT_VALID, 0);
            tick();
        end
        iRESULT_READY = 1'b1;
        fork
            push(37, 1, stalls);
            collect(37, 1, 1'b0);
        join

`ifdef ADDER_STREAM_CTRL_CARRY_CNT_EN
        iCARRY_CNT_CLR = 1'b1;
        tick();
        iCARRY_CNT_CLR = 1'b0;
        check("ccnt_clr0", oCARRY_CNT, 0);
        fork
            push(34, 5, stalls);
            collect(34, 5, 1'b0);
        join
        tick();
        check("ccnt_five", oCARRY_CNT, 5);
        iCARRY_CNT_CLR = 1'b1;
        tick();
        iCARRY_CNT_CLR = 1'b0;
        check("ccnt_clr", oCARRY_CNT, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
